serial_paralelo_param: RTL and testbench

SERIAL_PARALELO_PARAM -- requirements
Module: serial_paralelo_param

---
 rtl/serial_paralelo_pkg.sv | 27 ++
 rtl/sp_shift_align.sv | 47 ++++
 rtl/serial_paralelo_param.sv | 128 ++++++++++++
 tb/tb_serial_paralelo_param.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_paralelo_pkg.sv
// serial_paralelo_pkg
//   Shared definitions for the serial-to-parallel aligner:
//   - sp_state_e     : aligner FSM encoding (hunt / count / active)
//   - DEF_WIDTH      : default symbol width in bits
//   - DEF_COMMA      : default alignment/idle symbol
//   - DEF_LOCK_COUNT : default number of aligned commas needed for lock
//   - comma_cnt_width: width of the comma counter for a given lock count
package serial_paralelo_pkg;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,  // searching every bit position for a comma
        ST_COUNT  = 2'd1,  // boundary known, counting aligned commas
        ST_ACTIVE = 2'd2   // locked, delivering data symbols
    } sp_state_e;

    localparam int          DEF_WIDTH      = 8;
    localparam logic [7:0]  DEF_COMMA      = 8'hBC;
    localparam int          DEF_LOCK_COUNT = 4;

    // Counter must hold values 0..lock_count; never narrower than one bit.
    function automatic int comma_cnt_width(input int lock_count);
        int w;
        w = $clog2(lock_count + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sp_shift_align.sv
// sp_shift_align
//   Serial shift register plus symbol-boundary bit counter.
//   Ports:
//     clk_32f  in   serial bit clock
//     reset    in   synchronous, active-high reset
//     data_in  in   serial bit, MSB of each symbol first
//     run      in   high while the symbol boundary is known
//     cand     out  WIDTH-bit candidate symbol ending with this edge's bit
//     sym_done out  high on the edge that completes an aligned symbol
module sp_shift_align
    import serial_paralelo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             data_in,
    input  logic             run,
    output logic [WIDTH-1:0] cand,
    output logic             sym_done
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-2:0] sr;
    logic [CNT_W-1:0] bit_cnt;

    assign cand     = {sr, data_in};
    assign sym_done = run && (bit_cnt == CNT_W'(WIDTH - 1));

    // While hunting the counter is held at zero, so the edge that finds a
    // comma leaves it at zero and the next bit is bit 0 of the next symbol.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else begin
            sr <= cand[WIDTH-2:0];
            if (!run || sym_done) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/serial_paralelo_param.sv
// serial_paralelo_param
//   Serial-to-parallel converter with comma-based symbol alignment.
//   Hunts for COMMA at every bit position, confirms the boundary with
//   LOCK_COUNT aligned commas, then delivers each non-comma symbol.
//   Ports:
//     clk_32f   in   sole clock, one serial bit per rising edge
//     reset     in   synchronous, active-high reset
//     data_in   in   serial bit, MSB first
//     resync    in   single-cycle request to drop lock and re-hunt
//     data_out  out  last received non-comma symbol
//     valid_out out  one-cycle pulse when data_out takes a new symbol
//     active    out  high while locked
//     aligned   out  high while the symbol boundary is known
//   Handshake: valid_out is a pure pulse with no back-pressure; data_out
//   is valid in the cycle valid_out is high and holds until the next one.
module serial_paralelo_param
    import serial_paralelo_pkg::*;
#(
    parameter int               WIDTH      = DEF_WIDTH,
    parameter logic [WIDTH-1:0] COMMA      = WIDTH'(DEF_COMMA),
    parameter int               LOCK_COUNT = DEF_LOCK_COUNT
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             data_in,
    input  logic             resync,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             active,
    output logic             aligned
);

    localparam int CC_W = comma_cnt_width(LOCK_COUNT);
    localparam logic [CC_W-1:0] LOCK_VAL = CC_W'(LOCK_COUNT);

    sp_state_e        state_q, state_d;
    logic [CC_W-1:0]  comma_cnt_q, comma_cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    logic [WIDTH-1:0] cand;
    logic             sym_done;
    logic             is_comma;
    logic [CC_W-1:0]  comma_inc;

    sp_shift_align #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .data_in  (data_in),
        .run      (state_q != ST_HUNT),
        .cand     (cand),
        .sym_done (sym_done)
    );

    assign is_comma  = (cand == COMMA);
    assign comma_inc = comma_cnt_q + CC_W'(1);

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state_q     <= ST_HUNT;
            comma_cnt_q <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            comma_cnt_q <= comma_cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        comma_cnt_d = comma_cnt_q;
        data_d      = data_q;
        valid_d     = 1'b0;

        unique case (state_q)
            ST_HUNT: begin
                // Any bit position may start a symbol here.
                if (is_comma) begin
                    comma_cnt_d = CC_W'(1);
                    state_d     = (LOCK_COUNT == 1) ? ST_ACTIVE : ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (sym_done) begin
                    if (is_comma) begin
                        comma_cnt_d = comma_inc;
                        if (comma_inc == LOCK_VAL) begin
                            state_d = ST_ACTIVE;
                        end
                    end else begin
                        comma_cnt_d = '0;
                        state_d     = ST_HUNT;
                    end
                end
            end
            ST_ACTIVE: begin
                // Commas are idles once locked; they never move the boundary.
                if (sym_done && !is_comma) begin
                    data_d  = cand;
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_HUNT;
                comma_cnt_d = '0;
            end
        endcase

        // resync wins over a symbol completing on the same edge.
        if (resync) begin
            state_d     = ST_HUNT;
            comma_cnt_d = '0;
            valid_d     = 1'b0;
            data_d      = data_q;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign active    = (state_q == ST_ACTIVE);
    assign aligned   = (state_q != ST_HUNT);

endmodule

// File: tb/tb_serial_paralelo_param.sv
// Bench for serial_paralelo_param: a default instance (8-bit, BC, lock 4)
// and a 10-bit instance (17C, lock 1), both checked every cycle against a
// symbol-level reference model, plus a scoreboard of delivered symbols.
module tb_serial_paralelo_param;

    // ---------------- clock / reset ----------------
    logic clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    logic       rst_a = 1'b1, rsy_a = 1'b0, din_a = 1'b0;
    logic [7:0] dout_a;
    logic       val_a, act_a, ali_a;

    logic       rst_b = 1'b1, rsy_b = 1'b0, din_b = 1'b0;
    logic [9:0] dout_b;
    logic       val_b, act_b, ali_b;

    serial_paralelo_param dut_a (
        .clk_32f   (clk_32f),
        .reset     (rst_a),
        .data_in   (din_a),
        .resync    (rsy_a),
        .data_out  (dout_a),
        .valid_out (val_a),
        .active    (act_a),
        .aligned   (ali_a)
    );

    serial_paralelo_param #(
        .WIDTH      (10),
        .COMMA      (10'h17C),
        .LOCK_COUNT (1)
    ) dut_b (
        .clk_32f   (clk_32f),
        .reset     (rst_b),
        .data_in   (din_b),
        .resync    (rsy_b),
        .data_out  (dout_b),
        .valid_out (val_b),
        .active    (act_b),
        .aligned   (ali_b)
    );

    // ---------------- scoreboard / counters ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q_a[$];
    logic [9:0] exp_q_b[$];

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Per instance: mode 0=hunting, 1=boundary known, 2=locked.
    // pos counts bits received since the last symbol boundary.
    int m_w[2]    = '{8, 10};
    int m_comma[2]= '{'hBC, 'h17C};
    int m_lock[2] = '{4, 1};
    int m_mode[2] = '{0, 0};
    int m_ncom[2] = '{0, 0};
    int m_pos[2]  = '{0, 0};
    int m_win[2]  = '{0, 0};
    int m_data[2] = '{0, 0};
    int m_valid[2]= '{0, 0};

    task automatic model_step(input int id, input bit r, input bit s, input bit b);
        int mask;
        mask = (1 << m_w[id]) - 1;
        m_valid[id] = 0;
        if (r) begin
            m_mode[id] = 0; m_ncom[id] = 0; m_pos[id] = 0;
            m_win[id] = 0;  m_data[id] = 0;
            return;
        end
        // the last WIDTH bits received, newest in the LSB
        m_win[id] = ((m_win[id] << 1) | int'(b)) & mask;
        if (s) begin
            m_mode[id] = 0; m_ncom[id] = 0;
        end else if (m_mode[id] == 0) begin
            if (m_win[id] == m_comma[id]) begin
                m_pos[id]  = 0;
                m_ncom[id] = 1;
                m_mode[id] = (m_lock[id] == 1) ? 2 : 1;
            end
        end else begin
            m_pos[id]++;
            if (m_pos[id] == m_w[id]) begin
                m_pos[id] = 0;
                if (m_mode[id] == 1) begin
                    if (m_win[id] == m_comma[id]) begin
                        m_ncom[id]++;
                        if (m_ncom[id] >= m_lock[id]) m_mode[id] = 2;
                    end else begin
                        m_mode[id] = 0; m_ncom[id] = 0;
                    end
                end else if (m_win[id] != m_comma[id]) begin
                    m_data[id]  = m_win[id];
                    m_valid[id] = 1;
                    if (id == 0) exp_q_a.push_back(8'(m_win[id]));
                    else         exp_q_b.push_back(10'(m_win[id]));
                end
            end
        end
    endtask

    // One clock: inputs already set, advance model, sample #1 after edge.
    task automatic tick();
        @(posedge clk_32f);
        model_step(0, rst_a, rsy_a, din_a);
        model_step(1, rst_b, rsy_b, din_b);
        #1;
        check("a_valid",   val_a,  m_valid[0]);
        check("a_active",  act_a,  int'(m_mode[0] == 2));
        check("a_aligned", ali_a,  int'(m_mode[0] != 0));
        check("a_data",    dout_a, m_data[0]);
        check("b_valid",   val_b,  m_valid[1]);
        check("b_active",  act_b,  int'(m_mode[1] == 2));
        check("b_aligned", ali_b,  int'(m_mode[1] != 0));
        check("b_data",    dout_b, m_data[1]);
        if (val_a) begin
            check("a_sb_pending", int'(exp_q_a.size() > 0), 1);
            if (exp_q_a.size() > 0) check("a_sb_data", dout_a, exp_q_a.pop_front());
        end
        if (val_b) begin
            check("b_sb_pending", int'(exp_q_b.size() > 0), 1);
            if (exp_q_b.size() > 0) check("b_sb_data", dout_b, exp_q_b.pop_front());
        end
    endtask

    // ---------------- driver tasks ----------------
    // Send nbits of v MSB first; resync is raised on bit index rs_at.
    task automatic send_a(input int v, input int nbits, input int rs_at);
        for (int i = 0; i < nbits; i++) begin
            din_a = v[nbits-1-i];
            rsy_a = (i == rs_at);
            tick();
        end
        rsy_a = 1'b0;
    endtask

    task automatic send_b(input int v, input int nbits, input int rs_at);
        for (int i = 0; i < nbits; i++) begin
            din_b = v[nbits-1-i];
            rsy_b = (i == rs_at);
            tick();
        end
        rsy_b = 1'b0;
    endtask

    task automatic reset_a(input int n);
        rst_a = 1'b1;
        for (int i = 0; i < n; i++) begin
            din_a = 1'($urandom_range(0, 1));
            tick();
        end
        rst_a = 1'b0;
    endtask

    task automatic bc4_a();
        for (int i = 0; i < 4; i++) send_a('hBC, 8, -1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int r;

        // Reset state
        reset_a(3);
        rst_a = 1'b1;
        check("rst_data",    dout_a, 0);
        check("rst_valid",   val_a,  0);
        check("rst_active",  act_a,  0);
        check("rst_aligned", ali_a,  0);
        rst_a = 1'b0;

        // Default lock and delivery
        send_a('h00, 8, -1);
        for (int i = 0; i < 3; i++) send_a('hBC, 8, -1);
        check("dflt_aligned_3bc", ali_a, 1);
        check("dflt_active_3bc",  act_a, 0);
        send_a('hBC, 8, -1);
        check("dflt_active_4bc",  act_a, 1);
        send_a('hFF, 8, -1);
        check("dflt_ff_valid", val_a, 1);
        check("dflt_ff_data",  dout_a, 'hFF);
        send_a('hEE, 8, -1);
        check("dflt_ee_data",  dout_a, 'hEE);
        send_a('hBC, 8, -1);
        check("dflt_bc_novalid", val_a, 0);
        check("dflt_bc_hold",    dout_a, 'hEE);

        // Misalignment: stray 101 before the commas
        reset_a(2);
        send_a('b101, 3, -1);
        send_a('hBC, 8, -1);
        check("mis_aligned_1bc", ali_a, 1);
        for (int i = 0; i < 3; i++) send_a('hBC, 8, -1);
        check("mis_active", act_a, 1);
        send_a('h5A, 8, -1);
        check("mis_valid", val_a, 1);
        check("mis_data",  dout_a, 'h5A);

        // Broken lock
        reset_a(2);
        send_a('hBC, 8, -1);
        send_a('hBC, 8, -1);
        send_a('h3C, 8, -1);
        check("brk_aligned", ali_a, 0);
        check("brk_active",  act_a, 0);
        for (int i = 0; i < 3; i++) send_a('hBC, 8, -1);
        check("brk_not_yet", act_a, 0);
        send_a('hBC, 8, -1);
        check("brk_lock", act_a, 1);
        send_a('hA5, 8, -1);
        check("brk_data", dout_a, 'hA5);

        // resync mid-symbol, then on the completing edge
        send_a('hFF, 8, 3);
        check("rsy_mid_active", act_a, 0);
        check("rsy_mid_data",   dout_a, 'hA5);
        bc4_a();
        check("rsy_relock", act_a, 1);
        send_a('hFF, 8, 7);
        check("rsy_edge_valid",  val_a, 0);
        check("rsy_edge_active", act_a, 0);
        bc4_a();
        send_a('h77, 8, -1);
        check("rsy_edge_after", dout_a, 'h77);

        // Reset during the 3rd comma
        send_a('hBC, 8, -1);
        send_a('hBC, 8, -1);
        send_a('hB, 4, -1);
        rst_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din_a = 1'($urandom_range(0, 1));
            tick();
            check("mrst_data",   dout_a, 0);
            check("mrst_active", act_a,  0);
        end
        rst_a = 1'b0;
        for (int i = 0; i < 3; i++) send_a('hBC, 8, -1);
        check("mrst_not_yet", act_a, 0);
        send_a('hBC, 8, -1);
        check("mrst_lock", act_a, 1);
        send_a('h77, 8, -1);
        check("mrst_data77", dout_a, 'h77);

        // Randomized bursts on the default instance
        for (int k = 0; k < 25; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0) reset_a(1);
            else if (r < 3) send_a($urandom_range(0, 7), $urandom_range(1, 3), -1);
            bc4_a();
            for (int j = 0; j < 6; j++) begin
                r = $urandom_range(0, 99);
                if (r < 20)      send_a('hBC, 8, -1);
                else if (r < 26) send_a($urandom_range(0, 255), 8, $urandom_range(0, 7));
                else if (r < 30) send_a($urandom_range(0, 1), 1, -1);
                else             send_a($urandom_range(0, 255), 8, -1);
            end
        end

        // 10-bit instance, lock after a single comma
        rst_a = 1'b1;
        rst_b = 1'b0;
        send_b('h17C, 10, -1);
        check("p10_active", act_b, 1);
        send_b('h2AA, 10, -1);
        check("p10_valid", val_b, 1);
        check("p10_data",  dout_b, 'h2AA);
        send_b('h17C, 10, -1);
        check("p10_hold",  dout_b, 'h2AA);
        for (int k = 0; k < 15; k++) begin
            if ($urandom_range(0, 3) == 0) send_b($urandom_range(0, 3), 2, -1);
            send_b('h17C, 10, -1);
            for (int j = 0; j < 4; j++) begin
                r = $urandom_range(0, 99);
                if (r < 20)      send_b('h17C, 10, -1);
                else if (r < 28) send_b($urandom_range(0, 1023), 10, $urandom_range(0, 9));
                else             send_b($urandom_range(0, 1023), 10, -1);
            end
        end

        check("a_sb_left", exp_q_a.size(), 0);
        check("b_sb_left", exp_q_b.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
